control: RTL and testbench
==========================

# control

Instruction-decode control unit of the KGP-miniRISC processor. It takes the 6-bit opcode and 6-bit function field of the fetched instruction and produces every datapath steering signal: register-file destination and write enable, ALU/shifter selects, immediate selects, memory strobes, write-back source, and branch/jump type. Decode is combinational. The outputs are registered on the clock so the control word is aligned with the decode/execute boundary.

## Interface
- No parameters.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock; outputs update on its rising edge
- rst  in  1  asynchronous, active-high; forces the NOP control word
- opcode  in  6  instruction bits [31:26]
- func  in  6  function field; meaningful only for opcodes 000000 and 000001
- reg_dest_sel  out  2  00 = rs, 01 = rt, 10 = r31
- reg_write  out  1  register-file write enable
- immediate_sel  out  1  0 = sign-extended imm16 as ALU operand; 1 = sign-extended imm16 as memory offset
- alu_src_sel  out  1  0 = rt, 1 = immediate
- comp_enb  out  1  ALU produces the two's complement of operand B
- alu_operation_sel  out  2  00 add, 01 and, 10 xor, 11 diff
- shft_type_sel  out  1  0 = logical left, 1 = arithmetic right
- shft_amt_sel  out  1  0 = shamt field, 1 = rt register
- shft_enb  out  1  selects the shifter result for write-back
- branch_type  out  2  00 bltz, 01 bz, 10 bnz
- short_branch  out  1  conditional register-tested branch
- jump_type  out  2  00 b, 01 bl, 10 bcy, 11 bncy
- long_branch  out  1  26-bit-target branch
- mem_read  out  1  data-memory read strobe
- mem_write  out  1  data-memory write strobe
- reg_write_value_sel  out  2  00 ALU/shifter, 01 memory data, 10 PC+4
- branch_reg  out  1  PC <- rs (br)

## Operation
- NOP word: every output is 0.
- Each instruction drives only the fields listed below. All other outputs stay at 0.
- opcode 000000 (R-type ALU): reg_write = 1, dest rs, result from the ALU.
  - func 000001 add: op 00.
  - func 000010 comp: op 00, comp_enb = 1.
  - func 000011 and: op 01.
  - func 000100 xor: op 10.
  - func 000101 diff: op 11.
- opcode 000001 (shift): reg_write = 1, shft_enb = 1, dest rs.
  - func 000000 shll: type 0, amt 0.
  - func 000001 shllv: type 0, amt 1.
  - func 000010 shra: type 1, amt 0.
  - func 000011 shrav: type 1, amt 1.
- 000010 addi: reg_write = 1, alu_src_sel = 1, op 00, dest rs.
- 000011 compi: same as addi, plus comp_enb = 1.
- 000100 lw: reg_write = 1, dest rt, alu_src_sel = 1, immediate_sel = 1, mem_read = 1, reg_write_value_sel = 01.
- 000101 sw: alu_src_sel = 1, immediate_sel = 1, mem_write = 1.
- 000110 / 000111 / 001000: short_branch = 1, with branch_type 00 (bltz) / 01 (bz) / 10 (bnz) respectively.
- 001001 br: branch_reg = 1.
- 001010 / 001011 / 001100 / 001101: long_branch = 1, with jump_type 00 (b) / 01 (bl) / 10 (bcy) / 11 (bncy) respectively.
- bl additionally sets reg_write = 1, reg_dest_sel = 10, reg_write_value_sel = 10.
- Undefined opcode, or undefined func under 000000/000001: NOP word.
- func is ignored for every other opcode.
- mem_read and mem_write are never both 1. At most one of short_branch, long_branch and branch_reg is 1.

## Timing
- Decode is purely combinational from opcode/func.
- Every output is a flop loaded on the rising clk edge.
- Latency: inputs present before edge N appear on the outputs after edge N. There is no other state.
- rst = 1: all outputs go to 0 immediately, without waiting for a clock edge.
- While rst stays high, outputs hold 0 and clock edges are ignored.
- After rst deasserts, the first rising edge loads the decode of the current inputs.
- Reset asserted mid-stream discards the pending word; no partial update occurs.
- Input changes between edges do not affect the outputs.

## Test plan
- Reset: rst = 1 with opcode 000000, func 000001 -> all outputs 0, without any clock edge. Release rst, then one edge -> add word (reg_write = 1, op 00, dest 00, wb 00).
- R-type sweep: opcode 000000, func 000001..000101 on successive edges -> op 00/00/01/10/11, with comp_enb = 1 only for func 000010. func 000000 or 111111 -> all zero.
- Shifts: opcode 000001, func 000000..000011 -> (type, amt) = (0,0), (0,1), (1,0), (1,1), each with shft_enb = 1 and reg_write = 1.
- Memory: lw (000100) -> mem_read = 1, dest 01, wb 01, imm_sel = 1, alu_src = 1. sw (000101) -> mem_write = 1, reg_write = 0.
- Branches:
  - 000111 -> short_branch = 1, branch_type 01.
  - 001001 -> branch_reg = 1 only.
  - 001011 (bl) -> long_branch = 1, jump_type 01, reg_write = 1, dest 10, wb 10.
  - 001101 -> jump_type 11.
- Latency and illegal opcode: change opcode mid-cycle -> outputs change only at the next edge. opcode 111111 with any func -> all zero.

Source files
------------

// File: rtl/control_if.sv
// Decode bus of the KGP-miniRISC control unit: the instruction fields going in
// and the registered datapath control word coming out.
interface control_if;
    logic [5:0] opcode;
    logic [5:0] func;

    logic [1:0] reg_dest_sel;
    logic       reg_write;
    logic       immediate_sel;
    logic       alu_src_sel;
    logic       comp_enb;
    logic [1:0] alu_operation_sel;
    logic       shft_type_sel;
    logic       shft_amt_sel;
    logic       shft_enb;
    logic [1:0] branch_type;
    logic       short_branch;
    logic [1:0] jump_type;
    logic       long_branch;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] reg_write_value_sel;
    logic       branch_reg;

    modport master (
        output opcode, func,
        input  reg_dest_sel, reg_write, immediate_sel, alu_src_sel, comp_enb,
               alu_operation_sel, shft_type_sel, shft_amt_sel, shft_enb,
               branch_type, short_branch, jump_type, long_branch,
               mem_read, mem_write, reg_write_value_sel, branch_reg
    );

    modport slave (
        input  opcode, func,
        output reg_dest_sel, reg_write, immediate_sel, alu_src_sel, comp_enb,
               alu_operation_sel, shft_type_sel, shft_amt_sel, shft_enb,
               branch_type, short_branch, jump_type, long_branch,
               mem_read, mem_write, reg_write_value_sel, branch_reg
    );
endinterface

// File: rtl/control.sv
// KGP-miniRISC instruction decode: combinational opcode/func decode into a
// control word that is registered at the decode/execute boundary.
module control (
    input  logic      clk,
    input  logic      rst,
    control_if.slave  bus
);
    logic [1:0] n_reg_dest_sel;
    logic       n_reg_write;
    logic       n_immediate_sel;
    logic       n_alu_src_sel;
    logic       n_comp_enb;
    logic [1:0] n_alu_operation_sel;
    logic       n_shft_type_sel;
    logic       n_shft_amt_sel;
    logic       n_shft_enb;
    logic [1:0] n_branch_type;
    logic       n_short_branch;
    logic [1:0] n_jump_type;
    logic       n_long_branch;
    logic       n_mem_read;
    logic       n_mem_write;
    logic [1:0] n_reg_write_value_sel;
    logic       n_branch_reg;

    always_comb begin
        n_reg_dest_sel        = 2'b00;
        n_reg_write           = 1'b0;
        n_immediate_sel       = 1'b0;
        n_alu_src_sel         = 1'b0;
        n_comp_enb            = 1'b0;
        n_alu_operation_sel   = 2'b00;
        n_shft_type_sel       = 1'b0;
        n_shft_amt_sel        = 1'b0;
        n_shft_enb            = 1'b0;
        n_branch_type         = 2'b00;
        n_short_branch        = 1'b0;
        n_jump_type           = 2'b00;
        n_long_branch         = 1'b0;
        n_mem_read            = 1'b0;
        n_mem_write           = 1'b0;
        n_reg_write_value_sel = 2'b00;
        n_branch_reg          = 1'b0;

        case (bus.opcode)
            6'b000000: begin
                // An undefined func leaves the whole word at NOP.
                case (bus.func)
                    6'b000001: n_reg_write = 1'b1;
                    6'b000010: begin
                        n_reg_write = 1'b1;
                        n_comp_enb  = 1'b1;
                    end
                    6'b000011: begin
                        n_reg_write         = 1'b1;
                        n_alu_operation_sel = 2'b01;
                    end
                    6'b000100: begin
                        n_reg_write         = 1'b1;
                        n_alu_operation_sel = 2'b10;
                    end
                    6'b000101: begin
                        n_reg_write         = 1'b1;
                        n_alu_operation_sel = 2'b11;
                    end
                    default: ;
                endcase
            end
            6'b000001: begin
                if (bus.func[5:2] == 4'b0000) begin
                    n_reg_write     = 1'b1;
                    n_shft_enb      = 1'b1;
                    n_shft_type_sel = bus.func[1];
                    n_shft_amt_sel  = bus.func[0];
                end
            end
            6'b000010: begin
                n_reg_write   = 1'b1;
                n_alu_src_sel = 1'b1;
            end
            6'b000011: begin
                n_reg_write   = 1'b1;
                n_alu_src_sel = 1'b1;
                n_comp_enb    = 1'b1;
            end
            6'b000100: begin
                n_reg_write           = 1'b1;
                n_reg_dest_sel        = 2'b01;
                n_alu_src_sel         = 1'b1;
                n_immediate_sel       = 1'b1;
                n_mem_read            = 1'b1;
                n_reg_write_value_sel = 2'b01;
            end
            6'b000101: begin
                n_alu_src_sel   = 1'b1;
                n_immediate_sel = 1'b1;
                n_mem_write     = 1'b1;
            end
            6'b000110: n_short_branch = 1'b1;
            6'b000111: begin
                n_short_branch = 1'b1;
                n_branch_type  = 2'b01;
            end
            6'b001000: begin
                n_short_branch = 1'b1;
                n_branch_type  = 2'b10;
            end
            6'b001001: n_branch_reg = 1'b1;
            6'b001010: n_long_branch = 1'b1;
            6'b001011: begin
                n_long_branch         = 1'b1;
                n_jump_type           = 2'b01;
                n_reg_write           = 1'b1;
                n_reg_dest_sel        = 2'b10;
                n_reg_write_value_sel = 2'b10;
            end
            6'b001100: begin
                n_long_branch = 1'b1;
                n_jump_type   = 2'b10;
            end
            6'b001101: begin
                n_long_branch = 1'b1;
                n_jump_type   = 2'b11;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.reg_dest_sel        <= 2'b00;
            bus.reg_write           <= 1'b0;
            bus.immediate_sel       <= 1'b0;
            bus.alu_src_sel         <= 1'b0;
            bus.comp_enb            <= 1'b0;
            bus.alu_operation_sel   <= 2'b00;
            bus.shft_type_sel       <= 1'b0;
            bus.shft_amt_sel        <= 1'b0;
            bus.shft_enb            <= 1'b0;
            bus.branch_type         <= 2'b00;
            bus.short_branch        <= 1'b0;
            bus.jump_type           <= 2'b00;
            bus.long_branch         <= 1'b0;
            bus.mem_read            <= 1'b0;
            bus.mem_write           <= 1'b0;
            bus.reg_write_value_sel <= 2'b00;
            bus.branch_reg          <= 1'b0;
        end else begin
            bus.reg_dest_sel        <= n_reg_dest_sel;
            bus.reg_write           <= n_reg_write;
            bus.immediate_sel       <= n_immediate_sel;
            bus.alu_src_sel         <= n_alu_src_sel;
            bus.comp_enb            <= n_comp_enb;
            bus.alu_operation_sel   <= n_alu_operation_sel;
            bus.shft_type_sel       <= n_shft_type_sel;
            bus.shft_amt_sel        <= n_shft_amt_sel;
            bus.shft_enb            <= n_shft_enb;
            bus.branch_type         <= n_branch_type;
            bus.short_branch        <= n_short_branch;
            bus.jump_type           <= n_jump_type;
            bus.long_branch         <= n_long_branch;
            bus.mem_read            <= n_mem_read;
            bus.mem_write           <= n_mem_write;
            bus.reg_write_value_sel <= n_reg_write_value_sel;
            bus.branch_reg          <= n_branch_reg;
        end
    end
endmodule

// File: tb/tb_control.sv
// Directed bench for the control unit: hand-written expected control words
// checked one cycle after each instruction is presented.
module tb_control;
    typedef struct packed {
        logic [1:0] reg_dest_sel;
        logic       reg_write;
        logic       immediate_sel;
        logic       alu_src_sel;
        logic       comp_enb;
        logic [1:0] alu_operation_sel;
        logic       shft_type_sel;
        logic       shft_amt_sel;
        logic       shft_enb;
        logic [1:0] branch_type;
        logic       short_branch;
        logic [1:0] jump_type;
        logic       long_branch;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] reg_write_value_sel;
        logic       branch_reg;
    } cw_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    cw_t  e;

    control_if bus ();

    control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic cw_t observed();
        return {bus.reg_dest_sel, bus.reg_write, bus.immediate_sel, bus.alu_src_sel,
                bus.comp_enb, bus.alu_operation_sel, bus.shft_type_sel, bus.shft_amt_sel,
                bus.shft_enb, bus.branch_type, bus.short_branch, bus.jump_type,
                bus.long_branch, bus.mem_read, bus.mem_write, bus.reg_write_value_sel,
                bus.branch_reg};
    endfunction

    task automatic check(input string tag, input cw_t exp);
        cw_t obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present an instruction, let one rising edge load it, sample 1 time unit later.
    task automatic step(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.func   = fn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode = 6'b000000;
        bus.func   = 6'b000001;
        #1 rst = 1'b1;
        #1;
        e = '0;
        check("reset_async", e);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        e = '0; e.reg_write = 1'b1;
        check("add_after_reset", e);

        // R-type sweep
        step(6'b000000, 6'b000010);
        e = '0; e.reg_write = 1'b1; e.comp_enb = 1'b1;
        check("comp", e);
        step(6'b000000, 6'b000011);
        e = '0; e.reg_write = 1'b1; e.alu_operation_sel = 2'b01;
        check("and", e);
        step(6'b000000, 6'b000100);
        e = '0; e.reg_write = 1'b1; e.alu_operation_sel = 2'b10;
        check("xor", e);
        step(6'b000000, 6'b000101);
        e = '0; e.reg_write = 1'b1; e.alu_operation_sel = 2'b11;
        check("diff", e);
        step(6'b000000, 6'b000000);
        e = '0;
        check("rtype_func0", e);
        step(6'b000000, 6'b111111);
        check("rtype_func3f", e);
        step(6'b000000, 6'b000110);
        check("rtype_func6", e);

        // Shifts
        for (int i = 0; i < 4; i++) begin
            step(6'b000001, 6'(i));
            e = '0; e.reg_write = 1'b1; e.shft_enb = 1'b1;
            e.shft_type_sel = (i >= 2);
            e.shft_amt_sel  = (i == 1) || (i == 3);
            check($sformatf("shift_func%0d", i), e);
        end
        step(6'b000001, 6'b000100);
        e = '0;
        check("shift_func4", e);

        // Immediate ALU; func must be ignored
        step(6'b000010, 6'b101010);
        e = '0; e.reg_write = 1'b1; e.alu_src_sel = 1'b1;
        check("addi", e);
        step(6'b000011, 6'b111111);
        e.comp_enb = 1'b1;
        check("compi", e);

        // Memory
        step(6'b000100, 6'b000000);
        e = '0; e.reg_write = 1'b1; e.reg_dest_sel = 2'b01; e.alu_src_sel = 1'b1;
        e.immediate_sel = 1'b1; e.mem_read = 1'b1; e.reg_write_value_sel = 2'b01;
        check("lw", e);
        step(6'b000101, 6'b000000);
        e = '0; e.alu_src_sel = 1'b1; e.immediate_sel = 1'b1; e.mem_write = 1'b1;
        check("sw", e);

        // Branches
        step(6'b000110, 6'b000000);
        e = '0; e.short_branch = 1'b1;
        check("bltz", e);
        step(6'b000111, 6'b000000);
        e.branch_type = 2'b01;
        check("bz", e);
        step(6'b001000, 6'b000000);
        e.branch_type = 2'b10;
        check("bnz", e);
        step(6'b001001, 6'b000000);
        e = '0; e.branch_reg = 1'b1;
        check("br", e);
        step(6'b001010, 6'b000000);
        e = '0; e.long_branch = 1'b1;
        check("b", e);
        step(6'b001011, 6'b000000);
        e = '0; e.long_branch = 1'b1; e.jump_type = 2'b01; e.reg_write = 1'b1;
        e.reg_dest_sel = 2'b10; e.reg_write_value_sel = 2'b10;
        check("bl", e);
        step(6'b001100, 6'b000000);
        e = '0; e.long_branch = 1'b1; e.jump_type = 2'b10;
        check("bcy", e);
        step(6'b001101, 6'b000000);
        e.jump_type = 2'b11;
        check("bncy", e);

        // Latency: mid-cycle input change only shows after the next edge
        step(6'b000000, 6'b000001);
        e = '0; e.reg_write = 1'b1;
        bus.opcode = 6'b000101;
        #3;
        check("latency_hold", e);
        @(posedge clk);
        #1;
        e = '0; e.alu_src_sel = 1'b1; e.immediate_sel = 1'b1; e.mem_write = 1'b1;
        check("latency_update", e);

        // Illegal opcodes
        step(6'b111111, 6'b000001);
        e = '0;
        check("illegal_3f", e);
        step(6'b001110, 6'b000000);
        check("illegal_0e", e);

        // Reset mid-stream: immediate clear, edges ignored while held
        step(6'b000100, 6'b000000);
        #2 rst = 1'b1;
        #1;
        e = '0;
        check("reset_mid_async", e);
        @(posedge clk);
        #1;
        check("reset_held", e);
        rst = 1'b0;
        @(posedge clk);
        #1;
        e = '0; e.reg_write = 1'b1; e.reg_dest_sel = 2'b01; e.alu_src_sel = 1'b1;
        e.immediate_sel = 1'b1; e.mem_read = 1'b1; e.reg_write_value_sel = 2'b01;
        check("reset_release_load", e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
